// File: rtl/keccak_pkg.sv
// Shared Keccak absorb-path definitions: lane word geometry, SHAKE rates and controller states.
package keccak_pkg;

  localparam int W            = 64;
  localparam int W_BYTES      = W / 8;
  localparam int W_BYTE_WIDTH = $clog2(W_BYTES);

  localparam int RATE_WORDS_SHAKE128 = 21;
  localparam int RATE_WORDS_SHAKE256 = 17;

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    PERMUTE,
    FINISH
  } absorb_state_t;

endpackage

// File: rtl/absorb_controller.sv
// Sequences a SHAKE message into the absorb path one lane word per handshake and drives the padding generator.
// Optional: define ABSORB_CTRL_SHAKE128_EN to let `mode` select the SHAKE128 rate.
module absorb_controller
  import keccak_pkg::*;
#(
  parameter int MSG_LEN_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MSG_LEN_W-1:0]   msg_len,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W_BYTE_WIDTH:0]  remaining_valid_bytes,
  output logic                   padding_enable,
  output logic                   last_word_in_block,
  output logic                   padding_reset,
  output logic                   perm_start,
  input  logic                   perm_done,
  output logic                   busy,
  output logic                   done
);

  localparam logic [MSG_LEN_W-1:0] W_BYTES_L = MSG_LEN_W'(W_BYTES);

  absorb_state_t          state_q, state_d;
  logic [MSG_LEN_W-1:0]   bytes_left_q, bytes_left_d;
  logic [4:0]             word_idx_q, word_idx_d;
  logic [4:0]             rate_q, rate_d;
  logic                   pad_seen_q, pad_seen_d;
  logic                   perm_start_q, perm_start_d;
  logic [4:0]             rate_sel;

`ifdef ABSORB_CTRL_SHAKE128_EN
  assign rate_sel = mode ? 5'(RATE_WORDS_SHAKE128) : 5'(RATE_WORDS_SHAKE256);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign rate_sel    = 5'(RATE_WORDS_SHAKE256);
`endif

  always_comb begin
    state_d               = state_q;
    bytes_left_d          = bytes_left_q;
    word_idx_d            = word_idx_q;
    rate_d                = rate_q;
    pad_seen_d            = pad_seen_q;
    perm_start_d          = 1'b0;
    in_ready              = 1'b0;
    out_valid             = 1'b0;
    remaining_valid_bytes = '0;
    padding_enable        = 1'b0;
    last_word_in_block    = 1'b0;
    padding_reset         = 1'b0;
    done                  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          padding_reset = 1'b1;
          bytes_left_d  = msg_len;
          rate_d        = rate_sel;
          word_idx_d    = '0;
          pad_seen_d    = 1'b0;
          state_d       = ABSORB;
        end
      end

      ABSORB: begin
        last_word_in_block = (word_idx_q == rate_q - 5'd1);
        if (bytes_left_q >= W_BYTES_L) begin
          remaining_valid_bytes = (W_BYTE_WIDTH+1)'(W_BYTES);
          out_valid             = in_valid;
          in_ready              = out_ready;
        end else if (bytes_left_q != '0) begin
          remaining_valid_bytes = bytes_left_q[W_BYTE_WIDTH:0];
          padding_enable        = 1'b1;
          out_valid             = in_valid;
          in_ready              = out_ready;
        end else begin
          // Message exhausted: emit pure padding words without touching the input stream.
          padding_enable = 1'b1;
          out_valid      = 1'b1;
        end

        if (out_valid && out_ready) begin
          if (bytes_left_q >= W_BYTES_L) begin
            bytes_left_d = bytes_left_q - W_BYTES_L;
          end else begin
            bytes_left_d = '0;
            pad_seen_d   = 1'b1;
          end
          if (last_word_in_block) begin
            word_idx_d   = '0;
            perm_start_d = 1'b1;
            state_d      = PERMUTE;
          end else begin
            word_idx_d = word_idx_q + 5'd1;
          end
        end
      end

      PERMUTE: begin
        if (perm_done) begin
          state_d = pad_seen_q ? FINISH : ABSORB;
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bytes_left_q <= '0;
      word_idx_q   <= '0;
      rate_q       <= '0;
      pad_seen_q   <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      word_idx_q   <= word_idx_d;
      rate_q       <= rate_d;
      pad_seen_q   <= pad_seen_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign perm_start = perm_start_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_absorb_controller.sv
// Directed scoreboard bench for absorb_controller: expected words are queued per message and popped on each transfer.
module tb_absorb_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] msg_len = '0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  remaining_valid_bytes;
  logic        padding_enable;
  logic        last_word_in_block;
  logic        padding_reset;
  logic        perm_start;
  logic        perm_done = 1'b0;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int rvb;
    bit pad;
    bit last;
    bit inrdy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  absorb_controller #(.MSG_LEN_W(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .msg_len              (msg_len),
    .mode                 (mode),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .remaining_valid_bytes(remaining_valid_bytes),
    .padding_enable       (padding_enable),
    .last_word_in_block   (last_word_in_block),
    .padding_reset        (padding_reset),
    .perm_start           (perm_start),
    .perm_done            (perm_done),
    .busy                 (busy),
    .done                 (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_rate(input bit m);
`ifdef ABSORB_CTRL_SHAKE128_EN
    return m ? 21 : 17;
`else
    return 17;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_padding_reset"}, 32'(padding_reset), 0);
    chk({tag, "_perm_start"}, 32'(perm_start), 0);
    chk({tag, "_last"}, 32'(last_word_in_block), 0);
    chk({tag, "_pad_en"}, 32'(padding_enable), 0);
    chk({tag, "_rvb"}, 32'(remaining_valid_bytes), 0);
  endtask

  // One message end to end; negative arguments disable stall / abort / busy-start.
  task automatic run_msg(input int len, input bit m, input int stall_word, input int pd_lat,
                         input int abort_word, input int busy_start_word);
    int   rate = exp_rate(m);
    int   b = len;
    bit   padded = 0;
    int   nblk = 0;
    int   widx = 0;
    int   stall_left = 3;
    int   perms = 0;
    int   pd_cnt = -1;
    bit   got_done = 0;
    bit   last_pd = 0;
    bit   bs_done = 0;
    bit   snap_ok = 0;
    bit   aborted = 0;
    int   cyc = 0;
    logic [3:0] s_rvb;
    logic s_pad, s_last, s_ov, s_ir;
    exp_t e;

    exp_q.delete();
    do begin
      for (int i = 0; i < rate; i++) begin
        e.rvb   = (b >= 8) ? 8 : b;
        e.pad   = (b < 8);
        e.last  = (i == rate - 1);
        e.inrdy = (b > 0);
        if (b < 8) padded = 1;
        b -= e.rvb;
        exp_q.push_back(e);
      end
      nblk++;
    end while (!padded);

    @(posedge clk); #1;
    start = 1'b1; msg_len = 32'(len); mode = m;
    @(negedge clk);
    chk("start_padding_reset", 32'(padding_reset), 1);
    chk("start_idle_not_busy", 32'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;

    while (!got_done && cyc < 1000) begin
      cyc++;
      out_ready = !(widx == stall_word && stall_left > 0);
      if (busy_start_word >= 0 && widx == busy_start_word && !bs_done) begin
        start = 1'b1; msg_len = 32'd0; bs_done = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (abort_word >= 0 && widx == abort_word) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        aborted = 1;
        break;
      end
      if (perm_start) begin
        perms++;
        pd_cnt = pd_lat;
        chk("perm_out_valid", 32'(out_valid), 0);
        chk("perm_in_ready", 32'(in_ready), 0);
        chk("perm_at_boundary", 32'(widx % rate), 0);
      end
      if (pd_cnt == 0) begin
        perm_done = 1'b1; pd_cnt = -1;
      end else if (pd_cnt > 0) begin
        pd_cnt--;
      end
      if (done) begin
        chk("done_after_perm_done", 32'(last_pd), 1);
        got_done = 1;
      end
      if (out_valid && !out_ready) begin
        if (!snap_ok) begin
          s_rvb = remaining_valid_bytes; s_pad = padding_enable; s_last = last_word_in_block;
          s_ov = out_valid; s_ir = in_ready; snap_ok = 1;
        end else begin
          chk("stall_rvb", 32'(remaining_valid_bytes), 32'(s_rvb));
          chk("stall_pad_en", 32'(padding_enable), 32'(s_pad));
          chk("stall_last", 32'(last_word_in_block), 32'(s_last));
          chk("stall_out_valid", 32'(out_valid), 32'(s_ov));
          chk("stall_in_ready", 32'(in_ready), 32'(s_ir));
        end
        stall_left--;
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(widx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("w%0d_rvb", widx), 32'(remaining_valid_bytes), 32'(e.rvb));
          chk($sformatf("w%0d_pad_en", widx), 32'(padding_enable), 32'(e.pad));
          chk($sformatf("w%0d_last", widx), 32'(last_word_in_block), 32'(e.last));
          chk($sformatf("w%0d_in_ready", widx), 32'(in_ready), 32'(e.inrdy));
        end
        widx++;
      end
      @(posedge clk); #1;
      last_pd = perm_done;
      perm_done = 1'b0;
    end

    start = 1'b0;
    out_ready = 1'b1;
    if (aborted) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      chk("timeout", 32'(got_done), 1);
      chk("words_left_in_queue", 32'(exp_q.size()), 0);
      chk("perm_start_count", 32'(perms), 32'(nblk));
      @(negedge clk);
      chk("idle_after_done_busy", 32'(busy), 0);
      chk("idle_after_done_done", 32'(done), 0);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_msg(0,   1'b0, -1, 2, -1, -1);
    run_msg(5,   1'b0, -1, 0, -1, -1);
    run_msg(135, 1'b0, -1, 1, -1, 3);
    run_msg(136, 1'b0, -1, 3, -1, -1);
    run_msg(200, 1'b1, 10, 2, -1, -1);
    run_msg(200, 1'b0, -1, 2, 9, -1);
    run_msg(5,   1'b0, -1, 1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
